// File: rtl/reg_pkg.sv
// Shared types and constants for the register-bank hazard scoreboard.
// Optional build macro used by reg_scoreboard: REG_SB_WB_BYPASS_EN.
package reg_pkg;

    localparam int SB_NUM_REGS    = 16;
    localparam int SB_REG_W       = 4;
    localparam int SB_CNT_W       = 2;
    localparam int SB_STALL_CNT_W = 16;
    localparam logic [1:0] SB_FLUSH_GUARD = 2'd2;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] src1;
        logic [SB_REG_W-1:0] src2;
        logic                wr;
        logic [SB_REG_W-1:0] dst;
    } sb_issue_req_t;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] dst;
    } sb_wb_req_t;

endpackage

// File: rtl/sb_pend_cnt.sv
// Per-register pending-write counter: saturating up/down with clear.
// Simultaneous inc and dec cancel out; clr wins over both.
module sb_pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nz,
    output logic max,
    output logic one
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && !(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (|cnt)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign nz  = |cnt;
    assign max = &cnt;
    assign one = (cnt == CNT_W'(1));

endmodule

// File: rtl/reg_scoreboard.sv
// Hazard scoreboard for the decoder -> reg -> alu -> wb pipeline.
// Define REG_SB_WB_BYPASS_EN to let a dependent issue proceed in the writeback cycle.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int NUM_REGS    = SB_NUM_REGS,
    parameter int REG_W       = SB_REG_W,
    parameter int CNT_W       = SB_CNT_W,
    parameter int STALL_CNT_W = SB_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   issue_valid_i,
    input  logic [REG_W-1:0]       issue_src1_i,
    input  logic [REG_W-1:0]       issue_src2_i,
    input  logic                   issue_wr_i,
    input  logic [REG_W-1:0]       issue_dst_i,
    output logic                   issue_ready_o,
    output logic                   stall_o,
    input  logic                   wb_valid_i,
    input  logic [REG_W-1:0]       wb_dst_i,
    input  logic                   flush_i,
    output logic [NUM_REGS-1:0]    busy_mask_o,
    output logic                   idle_o,
    output logic                   err_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

`ifdef REG_SB_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    // Handshake: an issue transfers in a cycle where issue_valid_i and issue_ready_o are
    // both high; ready is a same-cycle function of state and inputs and never waits on valid.
    sb_issue_req_t iss;
    sb_wb_req_t    wb;

    logic [NUM_REGS-1:0] inc, dec, nz, mx, one;
    logic raw1, raw2, ovf, accept, retire, wb_err;
    logic [REG_W+CNT_W-1:0] inflight;
    logic [1:0]             flush_guard;
    logic                   err_q;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign iss = '{valid: issue_valid_i, src1: issue_src1_i, src2: issue_src2_i,
                   wr: issue_wr_i, dst: issue_dst_i};
    assign wb  = '{valid: wb_valid_i, dst: wb_dst_i};

    always_comb begin
        raw1   = nz[iss.src1];
        raw2   = nz[iss.src2];
        // Bank writes before it reads, so a last outstanding write retiring now satisfies the read.
        if (WB_BYPASS && wb.valid && one[wb.dst]) begin
            if (wb.dst == iss.src1) raw1 = 1'b0;
            if (wb.dst == iss.src2) raw2 = 1'b0;
        end
        ovf           = iss.wr & mx[iss.dst];
        issue_ready_o = ~flush_i & ~raw1 & ~raw2 & ~ovf;
        stall_o       = iss.valid & ~issue_ready_o;
        accept        = iss.valid & issue_ready_o & iss.wr;
        retire        = wb.valid & nz[wb.dst];
        wb_err        = wb.valid & ~nz[wb.dst];
        for (int r = 0; r < NUM_REGS; r++) begin
            inc[r] = accept & (iss.dst == REG_W'(r));
            dec[r] = retire & (wb.dst == REG_W'(r));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        sb_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .arstn (arstn),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .clr   (flush_i),
            .nz    (nz[g]),
            .max   (mx[g]),
            .one   (one[g])
        );
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            inflight    <= '0;
            flush_guard <= '0;
            err_q       <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (flush_i) begin
                inflight <= '0;
            end else if (accept && !retire) begin
                inflight <= inflight + (REG_W+CNT_W)'(1);
            end else if (retire && !accept) begin
                inflight <= inflight - (REG_W+CNT_W)'(1);
            end
            // Writebacks of instructions squashed by a flush may still drain shortly after it.
            if (flush_i) begin
                flush_guard <= SB_FLUSH_GUARD;
            end else if (flush_guard != 2'd0) begin
                flush_guard <= flush_guard - 2'd1;
            end
            if (wb_err && flush_guard == 2'd0) begin
                err_q <= 1'b1;
            end
            if (stall_o && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign busy_mask_o = nz;
    assign idle_o      = (inflight == '0);
    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios, random traffic against a
// per-register pending-count model, stall-counter saturation and mid-run reset.
module tb_reg_scoreboard;

`ifdef REG_SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        issue_valid_i, issue_wr_i, wb_valid_i, flush_i;
    logic [3:0]  issue_src1_i, issue_src2_i, issue_dst_i, wb_dst_i;
    logic        issue_ready_o, stall_o, idle_o, err_o;
    logic [15:0] busy_mask_o, stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    int m_pend [16];
    bit m_err;
    int m_guard;
    int m_stall;

    reg_scoreboard dut (
        .clk           (clk),
        .arstn         (arstn),
        .issue_valid_i (issue_valid_i),
        .issue_src1_i  (issue_src1_i),
        .issue_src2_i  (issue_src2_i),
        .issue_wr_i    (issue_wr_i),
        .issue_dst_i   (issue_dst_i),
        .issue_ready_o (issue_ready_o),
        .stall_o       (stall_o),
        .wb_valid_i    (wb_valid_i),
        .wb_dst_i      (wb_dst_i),
        .flush_i       (flush_i),
        .busy_mask_o   (busy_mask_o),
        .idle_o        (idle_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a source is readable when nothing is outstanding on it,
    // or (bypass build) when its single outstanding write lands this cycle.
    function automatic bit m_src_free(input int s);
        if (m_pend[s] == 0) return 1'b1;
        if (BYP && wb_valid_i && int'(wb_dst_i) == s && m_pend[s] == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return !flush_i && m_src_free(int'(issue_src1_i)) && m_src_free(int'(issue_src2_i))
               && !(issue_wr_i && m_pend[issue_dst_i] == 3);
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = (m_pend[r] != 0);
        return b;
    endfunction

    function automatic bit m_idle();
        int sum = 0;
        for (int r = 0; r < 16; r++) sum += m_pend[r];
        return sum == 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_pend[r] = 0;
        m_err = 1'b0;
        m_guard = 0;
        m_stall = 0;
    endtask

    task automatic model_update();
        bit rdy, acc, ret, bad;
        rdy = m_ready();
        acc = issue_valid_i && rdy && issue_wr_i;
        ret = wb_valid_i && m_pend[wb_dst_i] != 0;
        bad = wb_valid_i && m_pend[wb_dst_i] == 0 && m_guard == 0;
        if (issue_valid_i && !rdy && m_stall < 65535) m_stall++;
        if (flush_i) begin
            for (int r = 0; r < 16; r++) m_pend[r] = 0;
        end else begin
            if (acc) m_pend[issue_dst_i]++;
            if (ret) m_pend[wb_dst_i]--;
        end
        if (bad) m_err = 1'b1;
        m_guard = flush_i ? 2 : (m_guard > 0 ? m_guard - 1 : 0);
    endtask

    task automatic at_neg();
        @(negedge clk);
        chk("ready", 32'(issue_ready_o), 32'(m_ready()));
        chk("stall", 32'(stall_o), 32'(issue_valid_i && !m_ready()));
        chk("busy", 32'(busy_mask_o), 32'(m_busy()));
        chk("idle", 32'(idle_o), 32'(m_idle()));
        chk("err", 32'(err_o), 32'(m_err));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    endtask

    task automatic at_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    task automatic clear_in();
        issue_valid_i = 1'b0; issue_wr_i = 1'b0;
        issue_src1_i = 4'd0; issue_src2_i = 4'd0; issue_dst_i = 4'd0;
        wb_valid_i = 1'b0; wb_dst_i = 4'd0; flush_i = 1'b0;
    endtask

    task automatic set_issue(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                             input logic wr, input logic [3:0] d);
        issue_valid_i = v; issue_src1_i = s1; issue_src2_i = s2;
        issue_wr_i = wr; issue_dst_i = d;
    endtask

    // Reset asserted between clock edges; outputs must take reset values at once.
    task automatic do_reset();
        @(negedge clk);
        #2 arstn = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(busy_mask_o), 32'h0);
        chk("rst_idle", 32'(idle_o), 32'h1);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt_o), 32'h0);
        chk("rst_ready", 32'(issue_ready_o), 32'(!flush_i));
        chk("rst_stall", 32'(stall_o), 32'(issue_valid_i && flush_i));
        @(posedge clk);
        #1 arstn = 1'b1;
        clear_in();
    endtask

    initial begin
        clear_in();
        model_reset();
        do_reset();

        // RAW on r3, retired by writeback.
        set_issue(1, 0, 0, 1, 3); step();
        set_issue(1, 3, 0, 0, 0);
        at_neg();
        chk("t1_stall", 32'(stall_o), 32'h1);
        chk("t1_busy", 32'(busy_mask_o), 32'h0008);
        at_pos();
        wb_valid_i = 1; wb_dst_i = 3;
        at_neg();
        chk("t1_ready_wb_cycle", 32'(issue_ready_o), 32'(BYP));
        at_pos();
        wb_valid_i = 0;
        at_neg();
        chk("t1_ready_after_wb", 32'(issue_ready_o), 32'h1);
        at_pos();

        // Pending-counter overflow on r5.
        for (int i = 0; i < 3; i++) begin
            set_issue(1, 0, 0, 1, 5); step();
        end
        at_neg();
        chk("t2_ovf_ready", 32'(issue_ready_o), 32'h0);
        at_pos();
        wb_valid_i = 1; wb_dst_i = 5; step();
        wb_valid_i = 0;
        at_neg();
        chk("t2_after_wb_ready", 32'(issue_ready_o), 32'h1);
        at_pos();
        clear_in(); flush_i = 1; step();
        clear_in(); step(); step(); step();

        // Same-cycle accept and retire on r7.
        set_issue(1, 0, 0, 1, 7); step();
        wb_valid_i = 1; wb_dst_i = 7; step();
        clear_in();
        at_neg();
        chk("t3_busy7", 32'(busy_mask_o[7]), 32'h1);
        at_pos();
        wb_valid_i = 1; wb_dst_i = 7; step();
        clear_in(); step();

        // Stray writeback after a flush is tolerated; without a flush it is sticky.
        do_reset();
        flush_i = 1; step();
        clear_in(); wb_valid_i = 1; wb_dst_i = 9; step();
        clear_in(); step();
        at_neg();
        chk("t4_err_guarded", 32'(err_o), 32'h0);
        at_pos();
        wb_valid_i = 1; wb_dst_i = 9; step();
        clear_in();
        at_neg();
        chk("t4_err_set", 32'(err_o), 32'h1);
        at_pos();
        for (int i = 0; i < 3; i++) step();
        at_neg();
        chk("t4_err_held", 32'(err_o), 32'h1);
        at_pos();

        // Flush with pending writes and a simultaneous issue.
        set_issue(1, 0, 0, 1, 1); step();
        set_issue(1, 0, 0, 1, 2); step();
        set_issue(1, 0, 0, 1, 4); step();
        set_issue(1, 0, 0, 1, 6); flush_i = 1;
        at_neg();
        chk("t5_flush_ready", 32'(issue_ready_o), 32'h0);
        at_pos();
        clear_in();
        at_neg();
        chk("t5_busy", 32'(busy_mask_o), 32'h0);
        chk("t5_idle", 32'(idle_o), 32'h1);
        at_pos();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            set_issue(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)));
            wb_valid_i = 1'($urandom_range(0, 1));
            wb_dst_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_pend[wb_dst_i] == 0) wb_dst_i = 4'($urandom_range(0, 15));
                end
            end
            flush_i = ($urandom_range(0, 19) == 0);
            step();
        end

        // Stall-counter saturation.
        do_reset();
        set_issue(1, 0, 0, 1, 0); step();
        set_issue(1, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) at_pos();
        at_neg();
        chk("sat_stall_cnt", 32'(stall_cnt_o), 32'hFFFF);
        at_pos();

        // Reset in the middle of pending writes, with a flushing issue presented.
        clear_in();
        set_issue(1, 0, 0, 1, 2); step();
        set_issue(1, 0, 0, 1, 3); step();
        flush_i = 1;
        do_reset();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard controller for the register bank in the decoder → reg → alu → wb pipeline.
- Tracks in-flight writes per architectural register and stalls decoder issue on RAW hazards and on pending-counter overflow.
- Retires pending writes as writeback updates the bank.
- Gives the decoder a single ready/stall decision per cycle.

Parameters:
- NUM_REGS, 16, number of architectural registers.
- REG_W, 4, register index width; must equal clog2(NUM_REGS).
- CNT_W, 2, per-register pending-write counter width; maximum in-flight writes per register = 2^CNT_W-1.
- STALL_CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decoder presents an instruction for register read
- issue_src1_i  in  REG_W  first source register
- issue_src2_i  in  REG_W  second source register
- issue_wr_i  in  1  instruction writes a destination register
- issue_dst_i  in  REG_W  destination register
- issue_ready_o  out  1  instruction may advance this cycle
- stall_o  out  1  issue_valid_i & ~issue_ready_o
- wb_valid_i  in  1  writeback commits to the register bank this cycle
- wb_dst_i  in  REG_W  writeback destination
- flush_i  in  1  pipeline flush (branch taken)
- busy_mask_o  out  NUM_REGS  bit r set when pend[r] != 0
- idle_o  out  1  no writes in flight
- err_o  out  1  sticky: writeback to a register with no pending write
- stall_cnt_o  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
Reset:
- Asynchronous reset (arstn low) clears all pend[r] counters, err_o and stall_cnt_o.
- Values while in reset: busy_mask_o = 0, idle_o = 1, issue_ready_o = ~flush_i, stall_o = issue_valid_i & flush_i.

State:
- pend[r], CNT_W bits per register.
- Total in-flight count, width REG_W+CNT_W.
- err flag.
- Stall counter.

Hazard evaluation (combinational, same cycle):
- raw1 = pend[src1] != 0; raw2 = pend[src2] != 0.
- ovf = issue_wr_i & (pend[dst] == max).
- issue_ready_o = ~flush_i & ~raw1 & ~raw2 & ~ovf.
- Sources are always checked; the decoder supplies unused sources as a register whose pend is 0, or duplicates a checked source.

Accept and retire:
- Accept = issue_valid_i & issue_ready_o & issue_wr_i. On accept, pend[dst] increments at the next edge.
- Retire = wb_valid_i & pend[wb_dst] != 0. On retire, pend[wb_dst] decrements at the next edge.
- Accept and retire on the same register in the same cycle: counter unchanged.
- Accept and retire on different registers: both apply.

Error:
- wb_valid_i with pend[wb_dst] == 0: counter stays 0; err_o sets at the next edge and holds until reset.

Flush:
- flush_i forces issue_ready_o = 0 that cycle.
- At the next edge all pend counters clear, overriding any same-cycle accept or retire.
- Writebacks arriving after a flush that target cleared registers do NOT set err_o during the 2 cycles following the flush (flush_guard down-counter, value 2, reloaded on each flush).

Stall counter:
- stall_cnt_o increments each cycle stall_o = 1 and saturates at all-ones.

Outputs:
- busy_mask_o and idle_o are registered views of the pend state (no combinational path from inputs).

Latency:
- An issue accepted in cycle N is visible as busy in cycle N+1.
- A retire in cycle N frees the register in cycle N+1, unless REG_SB_WB_BYPASS_EN is defined.

Optional Feature:
Macro: REG_SB_WB_BYPASS_EN.
- Defined: a same-cycle retire on register r with pend[r] == 1 clears raw1/raw2 for r, so a dependent issue proceeds in the writeback cycle. This matches the bank's write-then-read timing.
- Undefined: a dependent instruction waits 1 extra cycle.
- Counter arithmetic is identical in both builds.

Decomposition:
- reg_pkg gains sb_issue_req_t {valid, src1, src2, wr, dst} and sb_wb_req_t {valid, dst}.
- reg_pkg also gains constants SB_CNT_W and SB_FLUSH_GUARD = 2.
- Natural sub-module: sb_pend_cnt, one per register, implemented via generate. It holds the saturating up/down counter with inc, dec and clr inputs and outputs nz and max.

Test Plan:
- Reset, then issue dst=3 with wr=1, then issue src1=3 → cycle 2 stall_o = 1, busy_mask_o = 0x0008. Writeback dst=3 → without bypass, ready in the cycle after the writeback. With bypass, ready in the writeback cycle.
- Three accepted writes to r5 with no writeback, then a fourth → pend[5] = 3, fourth stalls on ovf. One writeback on r5 → fourth accepted the next cycle.
- Same-cycle issue dst=7 and writeback dst=7 with pend[7] = 1 → pend[7] stays 1, busy_mask_o bit 7 stays set.
- Writeback r9 with pend[9] = 0 → err_o = 1 next cycle, held until reset. Writeback r9 one cycle after a flush → err_o stays 0.
- Pend on r1, r2, r4, then flush_i for 1 cycle with a simultaneous issue dst=6 → issue_ready_o = 0, next cycle busy_mask_o = 0 and idle_o = 1.
- Hold a stalled issue for 70000 cycles with STALL_CNT_W = 16 → stall_cnt_o saturates at 0xFFFF.
- Assert arstn low mid-pend → all outputs at reset values immediately.
